// File: rtl/mem_access_stage.sv
// MEM pipeline stage: resolves branches, issues loads/stores on a req/ready
// data-memory bus, holds the pipeline while an access is outstanding and
// produces the MEM/WB register.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | sampling EX/MEM; ALU ops pass through, aligned mem ops issue
// S_WAIT | request outstanding; bus signals held until dmem_ready
module mem_access_stage #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Ctl_MemtoReg_in,
  input  logic              Ctl_RegWrite_in,
  input  logic              Ctl_MemRead_in,
  input  logic              Ctl_MemWrite_in,
  input  logic              Ctl_Branch_in,
  input  logic              Zero_in,
  input  logic [2:0]        funct3_in,
  input  logic [4:0]        Rd_in,
  input  logic [31:0]       ALUresult_in,
  input  logic [31:0]       ReadData2_in,
  input  logic [31:0]       PCimm_in,
  output logic              PCSrc_out,
  output logic [31:0]       PCbranch_out,
  output logic              stall_out,
  output logic              misalign_out,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  output logic [3:0]        dmem_be,
  input  logic              dmem_ready,
  input  logic [31:0]       dmem_rdata,
  output logic              Ctl_MemtoReg_out,
  output logic              Ctl_RegWrite_out,
  output logic [4:0]        Rd_out,
  output logic [31:0]       ReadData_out,
  output logic [31:0]       ALUresult_out
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t      state_q, state_d;
  logic        mem_op;
  logic        aligned;
  logic [1:0]  off;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;
  logic        issue;
  logic [31:0] shifted;
  logic [31:0] load_data;

  // Operation context captured at issue, used when the response arrives.
  logic [2:0]  op_f3;
  logic [1:0]  op_off;
  logic        op_load;
  logic        op_m2r;
  logic        op_rw;
  logic [4:0]  op_rd;
  logic [31:0] op_alu;

  // Branch resolution: bne inverts the Zero flag, other branches use it directly.
  always_comb begin
    PCSrc_out    = Ctl_Branch_in & (Zero_in ^ (funct3_in == 3'b001));
    PCbranch_out = PCimm_in;
  end

  // Access size decode: alignment check, byte enables and lane-replicated store data.
  always_comb begin
    mem_op     = Ctl_MemRead_in | Ctl_MemWrite_in;
    off        = ALUresult_in[1:0];
    aligned    = 1'b0;
    be_calc    = 4'b0000;
    wdata_calc = 32'h0;
    case (funct3_in[1:0])
      2'b00: begin
        aligned    = 1'b1;
        be_calc    = 4'b0001 << off;
        wdata_calc = {4{ReadData2_in[7:0]}};
      end
      2'b01: begin
        aligned    = ~off[0];
        be_calc    = 4'b0011 << off;
        wdata_calc = {2{ReadData2_in[15:0]}};
      end
      2'b10: begin
        aligned    = (off == 2'b00);
        be_calc    = 4'b1111;
        wdata_calc = ReadData2_in;
      end
      default: begin
        aligned    = 1'b0;
      end
    endcase
  end

  // Next-state, stall and request generation.
  always_comb begin
    state_d   = state_q;
    stall_out = 1'b0;
    issue     = 1'b0;
    dmem_req  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mem_op && aligned) begin
          stall_out = 1'b1;
          issue     = 1'b1;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        dmem_req  = 1'b1;
        stall_out = ~dmem_ready;
        if (dmem_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Load lane extraction and sign/zero extension from the captured offset.
  always_comb begin
    shifted = dmem_rdata >> {op_off, 3'b000};
    case (op_f3)
      3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_data = {24'h0, shifted[7:0]};
      3'b101:  load_data = {16'h0, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Bus request registers, captured context and MEM/WB register.
  always_ff @(posedge clk) begin
    if (rst) begin
      dmem_we          <= 1'b0;
      dmem_be          <= 4'b0000;
      dmem_addr        <= '0;
      dmem_wdata       <= 32'h0;
      misalign_out     <= 1'b0;
      Ctl_MemtoReg_out <= 1'b0;
      Ctl_RegWrite_out <= 1'b0;
      Rd_out           <= 5'd0;
      ReadData_out     <= 32'h0;
      ALUresult_out    <= 32'h0;
      op_f3            <= 3'b000;
      op_off           <= 2'b00;
      op_load          <= 1'b0;
      op_m2r           <= 1'b0;
      op_rw            <= 1'b0;
      op_rd            <= 5'd0;
      op_alu           <= 32'h0;
    end else begin
      misalign_out <= (state_q == S_IDLE) && mem_op && !aligned;
      if (state_q == S_IDLE) begin
        // Memory ops leave a bubble behind; their results arrive on completion.
        Ctl_MemtoReg_out <= mem_op ? 1'b0 : Ctl_MemtoReg_in;
        Ctl_RegWrite_out <= mem_op ? 1'b0 : Ctl_RegWrite_in;
        Rd_out           <= Rd_in;
        ALUresult_out    <= ALUresult_in;
        ReadData_out     <= 32'h0;
        if (issue) begin
          dmem_addr  <= {ALUresult_in[ADDR_W-1:2], 2'b00};
          dmem_we    <= Ctl_MemWrite_in & ~Ctl_MemRead_in;
          dmem_be    <= be_calc;
          dmem_wdata <= wdata_calc;
          op_f3      <= funct3_in;
          op_off     <= off;
          op_load    <= Ctl_MemRead_in;
          op_m2r     <= Ctl_MemtoReg_in;
          op_rw      <= Ctl_RegWrite_in;
          op_rd      <= Rd_in;
          op_alu     <= ALUresult_in;
        end
      end else if (dmem_ready) begin
        Ctl_MemtoReg_out <= op_m2r;
        Ctl_RegWrite_out <= op_rw;
        Rd_out           <= op_rd;
        ALUresult_out    <= op_alu;
        ReadData_out     <= op_load ? load_data : 32'h0;
      end
    end
  end

endmodule
